// File: rtl/mem_stage_if.sv
// EX->MEM->WB bus bundle for the memory stage.
//   master: the surrounding pipeline (drives stall, EX buses, SRAM read data;
//           receives the WB buses, forwarding taps and the load-alignment flag)
//   slave : mem_stage
interface mem_stage_if #(
  parameter int unsigned STALL_W = 6
);
  localparam int unsigned EX_W   = 79;
  localparam int unsigned HILO_W = 66;
  localparam int unsigned WB_W   = 70;

  logic [STALL_W-1:0] stall;
  logic [EX_W-1:0]    ex_to_mem_bus;
  logic [HILO_W-1:0]  hilo_ex_to_mem_bus;
  logic [31:0]        data_sram_rdata;

  logic [WB_W-1:0]    mem_to_wb_bus;
  logic [HILO_W-1:0]  hilo_mem_to_wb_bus;
  logic               mem_wreg;
  logic [4:0]         mem_waddr;
  logic [31:0]        mem_wdata;
  logic               mem_hi_we;
  logic               mem_lo_we;
  logic [31:0]        mem_hi_wdata;
  logic [31:0]        mem_lo_wdata;
  logic               mem_adel;

  modport master (
    output stall, ex_to_mem_bus, hilo_ex_to_mem_bus, data_sram_rdata,
    input  mem_to_wb_bus, hilo_mem_to_wb_bus, mem_wreg, mem_waddr, mem_wdata,
           mem_hi_we, mem_lo_we, mem_hi_wdata, mem_lo_wdata, mem_adel
  );

  modport slave (
    input  stall, ex_to_mem_bus, hilo_ex_to_mem_bus, data_sram_rdata,
    output mem_to_wb_bus, hilo_mem_to_wb_bus, mem_wreg, mem_waddr, mem_wdata,
           mem_hi_we, mem_lo_we, mem_hi_wdata, mem_lo_wdata, mem_adel
  );
endinterface

// File: rtl/mem_stage.sv
// Memory pipeline stage: EX/MEM register, load data extraction/extension,
// misaligned-load detection and an rdata hold register that keeps the SRAM
// word stable while MEM is stalled.
// Ports:
//   clk - rising-edge clock
//   rst - synchronous active-high reset
//   bus - mem_stage_if.slave (stall, EX buses, SRAM rdata in; WB buses,
//         GPR/HI/LO forwarding taps and mem_adel out, all combinational
//         from the MEM and hold registers)
module mem_stage #(
  parameter int unsigned STALL_W = 6
) (
  input  logic         clk,
  input  logic         rst,
  mem_stage_if.slave   bus
);

  localparam int unsigned EX_W   = 79;
  localparam int unsigned HILO_W = 66;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_HELD  = 1'b1;

  localparam logic [2:0] OP_LB  = 3'b001;
  localparam logic [2:0] OP_LBU = 3'b010;
  localparam logic [2:0] OP_LH  = 3'b011;
  localparam logic [2:0] OP_LHU = 3'b100;

  logic [STALL_W-1:0] stall_c;
  logic               stall_ex_c;
  logic               stall_mem_c;
  logic               stall_unused_c;

  logic [EX_W-1:0]    ex_q;
  logic [HILO_W-1:0]  hilo_q;

  logic [0:0]         state_q, state_d;
  logic [31:0]        hold_q, hold_d;

  logic [31:0] pc_c;
  logic [2:0]  load_op_c;
  logic        ram_en_c;
  logic [3:0]  ram_wen_c;
  logic        sel_rf_res_c;
  logic        rf_we_c;
  logic [4:0]  rf_waddr_c;
  logic [31:0] ex_result_c;
  logic [1:0]  addr_c;

  logic        is_load_c;
  logic        is_half_c;
  logic        is_word_c;
  logic [31:0] word_c;
  logic [7:0]  byte_c;
  logic [15:0] half_c;
  logic [31:0] load_data_c;
  logic        adel_c;
  logic        rf_we_out_c;
  logic [31:0] rf_wdata_c;

  assign stall_c        = bus.stall;
  assign stall_ex_c     = stall_c[3];
  assign stall_mem_c    = stall_c[4];
  assign stall_unused_c = ^{stall_c[STALL_W-1:5], stall_c[2:0]};

  // EX/MEM register: reset, then bubble, then capture, else hold
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q   <= '0;
      hilo_q <= '0;
    end else if (stall_ex_c && !stall_mem_c) begin
      ex_q   <= '0;
      hilo_q <= '0;
    end else if (!stall_ex_c) begin
      ex_q   <= bus.ex_to_mem_bus;
      hilo_q <= bus.hilo_ex_to_mem_bus;
    end
  end

  // Registered field view
  assign pc_c         = ex_q[78:47];
  assign load_op_c    = ex_q[46:44];
  assign ram_en_c     = ex_q[43];
  assign ram_wen_c    = ex_q[42:39];
  assign sel_rf_res_c = ex_q[38];
  assign rf_we_c      = ex_q[37];
  assign rf_waddr_c   = ex_q[36:32];
  assign ex_result_c  = ex_q[31:0];
  assign addr_c       = ex_result_c[1:0];

  assign is_load_c = ram_en_c && (ram_wen_c == 4'b0000) && sel_rf_res_c;

  // Hold FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  // Hold FSM next state: a new MEM capture releases the held word first
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    if (!stall_ex_c) begin
      state_d = ST_EMPTY;
    end else if ((state_q == ST_EMPTY) && is_load_c && stall_mem_c) begin
      state_d = ST_HELD;
      hold_d  = bus.data_sram_rdata;
    end
  end

  // Load extraction and extension
  always_comb begin
    word_c = (state_q == ST_HELD) ? hold_q : bus.data_sram_rdata;

    case (addr_c)
      2'd0:    byte_c = word_c[7:0];
      2'd1:    byte_c = word_c[15:8];
      2'd2:    byte_c = word_c[23:16];
      default: byte_c = word_c[31:24];
    endcase

    half_c = addr_c[1] ? word_c[31:16] : word_c[15:0];

    case (load_op_c)
      OP_LB:   load_data_c = {{24{byte_c[7]}}, byte_c};
      OP_LBU:  load_data_c = {24'h0, byte_c};
      OP_LH:   load_data_c = {{16{half_c[15]}}, half_c};
      OP_LHU:  load_data_c = {16'h0, half_c};
      default: load_data_c = word_c;
    endcase
  end

  // Misaligned load detection; unlisted op codes behave as LW
  assign is_half_c = (load_op_c == OP_LH) || (load_op_c == OP_LHU);
  assign is_word_c = !(is_half_c || (load_op_c == OP_LB) || (load_op_c == OP_LBU));
  assign adel_c    = is_load_c &&
                     ((is_half_c && addr_c[0]) || (is_word_c && (addr_c != 2'b00)));

  assign rf_we_out_c = rf_we_c && !adel_c;
  assign rf_wdata_c  = sel_rf_res_c ? load_data_c : ex_result_c;

  assign bus.mem_to_wb_bus      = {pc_c, rf_we_out_c, rf_waddr_c, rf_wdata_c};
  assign bus.hilo_mem_to_wb_bus = hilo_q;
  assign bus.mem_wreg           = rf_we_out_c;
  assign bus.mem_waddr          = rf_waddr_c;
  assign bus.mem_wdata          = rf_wdata_c;
  assign bus.mem_hi_wdata       = hilo_q[65:34];
  assign bus.mem_lo_wdata       = hilo_q[33:2];
  assign bus.mem_hi_we          = hilo_q[1];
  assign bus.mem_lo_we          = hilo_q[0];
  assign bus.mem_adel           = adel_c;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a scoreboard of expected WB results.
module tb_mem_stage;

  typedef struct packed {
    logic [69:0] wb;
    logic [69:0] mask;
    logic [65:0] hilo;
    logic        adel;
  } exp_t;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  exp_t sb_q[$];

  mem_stage_if #(.STALL_W(6)) ifc ();

  mem_stage #(.STALL_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic [78:0] mk_ex(input logic [31:0] pc, input logic [2:0] op,
                                        input logic en, input logic [3:0] wen,
                                        input logic sel, input logic we,
                                        input logic [4:0] wa, input logic [31:0] res);
    return {pc, op, en, wen, sel, we, wa, res};
  endfunction

  function automatic logic [78:0] mk_ld(input logic [31:0] pc, input logic [2:0] op,
                                        input logic [31:0] addr, input logic [4:0] wa);
    return mk_ex(pc, op, 1'b1, 4'h0, 1'b1, 1'b1, wa, addr);
  endfunction

  // Reference behaviour of one instruction sitting in MEM with SRAM word rd
  function automatic exp_t model(input logic [78:0] ex, input logic [65:0] hilo,
                                 input logic [31:0] rd);
    exp_t        e;
    logic [2:0]  op;
    logic [31:0] res;
    logic [1:0]  a;
    logic        ld;
    logic        mis;
    logic [7:0]  b8;
    logic [15:0] h16;
    logic [31:0] sh;
    logic [31:0] val;
    op  = ex[46:44];
    res = ex[31:0];
    a   = res[1:0];
    ld  = ex[43] && (ex[42:39] == 4'h0) && ex[38];
    sh  = rd >> (8 * a);
    b8  = sh[7:0];
    sh  = rd >> (16 * a[1]);
    h16 = sh[15:0];
    case (op)
      3'd1:    val = {{24{b8[7]}}, b8};
      3'd2:    val = {24'h0, b8};
      3'd3:    val = {{16{h16[15]}}, h16};
      3'd4:    val = {16'h0, h16};
      default: val = rd;
    endcase
    mis = ld && ((((op == 3'd3) || (op == 3'd4)) && a[0]) ||
                 (!(op inside {3'd1, 3'd2, 3'd3, 3'd4}) && (a != 2'b00)));
    e.wb   = {ex[78:47], ex[37] & ~mis, ex[36:32], ex[38] ? val : res};
    e.mask = {{38{1'b1}}, {32{~mis}}};
    e.hilo = hilo;
    e.adel = mis;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [78:0] ex, input logic [65:0] hilo,
                       input logic [5:0] st, input logic r);
    ifc.ex_to_mem_bus      = ex;
    ifc.hilo_ex_to_mem_bus = hilo;
    ifc.stall              = st;
    rst                    = r;
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [31:0] rd);
    exp_t e;
    ifc.data_sram_rdata = rd;
    #1;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: scoreboard empty, observed wb %h", tag, ifc.mem_to_wb_bus);
      return;
    end
    e = sb_q.pop_front();
    chk({tag, "_wb"},    70'(ifc.mem_to_wb_bus & e.mask), 70'(e.wb & e.mask));
    chk({tag, "_hilo"},  70'(ifc.hilo_mem_to_wb_bus), 70'(e.hilo));
    chk({tag, "_adel"},  70'(ifc.mem_adel), 70'(e.adel));
    chk({tag, "_wreg"},  70'(ifc.mem_wreg), 70'(e.wb[37]));
    chk({tag, "_waddr"}, 70'(ifc.mem_waddr), 70'(e.wb[36:32]));
    chk({tag, "_wdata"}, 70'(ifc.mem_wdata & e.mask[31:0]), 70'(e.wb[31:0] & e.mask[31:0]));
    chk({tag, "_hi_we"}, 70'(ifc.mem_hi_we), 70'(e.hilo[1]));
    chk({tag, "_lo_we"}, 70'(ifc.mem_lo_we), 70'(e.hilo[0]));
    chk({tag, "_hi_wd"}, 70'(ifc.mem_hi_wdata), 70'(e.hilo[65:34]));
    chk({tag, "_lo_wd"}, 70'(ifc.mem_lo_wdata), 70'(e.hilo[33:2]));
  endtask

  initial begin
    logic [78:0] ex;
    logic [65:0] hl;
    exp_t        zero_e;
    errors = 0;
    checks = 0;
    zero_e = '{wb: '0, mask: '1, hilo: '0, adel: 1'b0};
    ifc.data_sram_rdata    = 32'h0;
    ifc.ex_to_mem_bus      = '0;
    ifc.hilo_ex_to_mem_bus = '0;
    ifc.stall              = 6'b0;
    rst                    = 1'b1;
    hl = {32'h1, 32'h2, 1'b1, 1'b1};

    // Reset state
    sb_q.push_back(zero_e);
    drive(mk_ld(32'hBFC0_0000, 3'd1, 32'h3, 5'd7), hl, 6'b0, 1'b1);
    check_out("reset", 32'hFFFF_FFFF);
    chk("reset_state", 70'(dut.state_q), 70'(1'b0));

    // Directed loads: {pc, op, addr, waddr, rdata}
    ex = mk_ld(32'h0000_0100, 3'd1, 32'h0000_1003, 5'd3);
    sb_q.push_back(model(ex, '0, 32'h80FF_1234));
    drive(ex, '0, 6'b0, 1'b0);
    check_out("lb_a3", 32'h80FF_1234);

    ex = mk_ld(32'h0000_0104, 3'd4, 32'h0000_2002, 5'd4);
    sb_q.push_back(model(ex, '0, 32'h8001_7FFF));
    drive(ex, '0, 6'b0, 1'b0);
    check_out("lhu_a2", 32'h8001_7FFF);

    ex = mk_ld(32'h0000_0108, 3'd3, 32'h0000_2001, 5'd6);
    sb_q.push_back(model(ex, '0, 32'h8001_7FFF));
    drive(ex, '0, 6'b0, 1'b0);
    check_out("lh_a1_adel", 32'h8001_7FFF);

    ex = mk_ld(32'h0000_010C, 3'd2, 32'h0000_0041, 5'd8);
    sb_q.push_back(model(ex, '0, 32'h0000_F000));
    drive(ex, '0, 6'b0, 1'b0);
    check_out("lbu_a1", 32'h0000_F000);

    ex = mk_ld(32'h0000_0110, 3'd3, 32'h0000_0042, 5'd9);
    sb_q.push_back(model(ex, '0, 32'h8000_1111));
    drive(ex, '0, 6'b0, 1'b0);
    check_out("lh_a2", 32'h8000_1111);

    ex = mk_ld(32'h0000_0114, 3'd7, 32'h0000_0080, 5'd10);
    sb_q.push_back(model(ex, '0, 32'hA5A5_5A5A));
    drive(ex, '0, 6'b0, 1'b0);
    check_out("lw_op7", 32'hA5A5_5A5A);

    ex = mk_ld(32'h0000_0118, 3'd0, 32'h0000_0082, 5'd11);
    sb_q.push_back(model(ex, '0, 32'hA5A5_5A5A));
    drive(ex, '0, 6'b0, 1'b0);
    check_out("lw_a2_adel", 32'hA5A5_5A5A);

    // Store to an unaligned address is not a load: no adel
    ex = mk_ex(32'h0000_011C, 3'd0, 1'b1, 4'hF, 1'b0, 1'b0, 5'd0, 32'h0000_0083);
    sb_q.push_back(model(ex, '0, 32'h0));
    drive(ex, '0, 6'b0, 1'b0);
    check_out("store_a3", 32'h0);

    // ALU op with HI/LO writes
    ex = mk_ex(32'h0000_0120, 3'd0, 1'b0, 4'h0, 1'b0, 1'b1, 5'd5, 32'h0000_00AA);
    sb_q.push_back(model(ex, hl, 32'hFFFF_FFFF));
    drive(ex, hl, 6'b0, 1'b0);
    check_out("alu_hilo", 32'hFFFF_FFFF);

    // LW held across a three-cycle MEM stall while rdata changes
    ex = mk_ld(32'h0000_0200, 3'd0, 32'h0000_0100, 5'd12);
    sb_q.push_back(model(ex, '0, 32'h1234_5678));
    drive(ex, '0, 6'b0, 1'b0);
    check_out("lw_hold0", 32'h1234_5678);
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back(model(ex, '0, 32'h1234_5678));
      drive(mk_ld(32'h0000_0204, 3'd0, 32'h0, 5'd13), hl, 6'b011000, 1'b0);
      check_out($sformatf("lw_hold%0d", i + 1), 32'hDEAD_BEEF);
    end
    // Release: next instruction sees live rdata again
    ex = mk_ld(32'h0000_0204, 3'd0, 32'h0000_0004, 5'd13);
    sb_q.push_back(model(ex, '0, 32'hDEAD_BEEF));
    drive(ex, '0, 6'b0, 1'b0);
    check_out("lw_release", 32'hDEAD_BEEF);

    // Bubble: EX stalled, MEM running
    sb_q.push_back(zero_e);
    drive(mk_ld(32'h0000_0300, 3'd1, 32'h3, 5'd14), hl, 6'b001000, 1'b0);
    check_out("bubble", 32'h8080_8080);

    // Reset while HELD
    ex = mk_ld(32'h0000_0400, 3'd0, 32'h0000_0010, 5'd15);
    sb_q.push_back(model(ex, hl, 32'h1111_2222));
    drive(ex, hl, 6'b0, 1'b0);
    check_out("pre_rst0", 32'h1111_2222);
    sb_q.push_back(model(ex, hl, 32'h1111_2222));
    drive(mk_ld(32'h0000_0404, 3'd0, 32'h0, 5'd1), hl, 6'b011000, 1'b0);
    check_out("pre_rst1", 32'h3333_4444);
    sb_q.push_back(zero_e);
    drive(mk_ld(32'h0000_0404, 3'd0, 32'h0, 5'd1), hl, 6'b011000, 1'b1);
    check_out("rst_held", 32'h5555_6666);
    chk("rst_held_state", 70'(dut.state_q), 70'(1'b0));
    chk("rst_held_word", 70'(dut.hold_q), 70'(32'h0));

    // Normal operation after reset
    ex = mk_ld(32'h0000_0500, 3'd3, 32'h0000_0002, 5'd2);
    sb_q.push_back(model(ex, '0, 32'hFFFE_0000));
    drive(ex, '0, 6'b0, 1'b0);
    check_out("post_rst_lh", 32'hFFFE_0000);

    chk("sb_drained", 70'(sb_q.size()), 70'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The block SHALL use the parameter STALL_W, default 6, as the width of the stall bus.
REQ-002 The block SHALL use clock clk and reset rst; rst SHALL be synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 stall  in  STALL_W  per-stage stop flags; bit3 = EX, bit4 = MEM, 1 = stop.
REQ-006 ex_to_mem_bus  in  79  {pc[78:47], load_op[46:44], data_ram_en[43], data_ram_wen[42:39], sel_rf_res[38], rf_we[37], rf_waddr[36:32], ex_result[31:0]}.
REQ-007 hilo_ex_to_mem_bus  in  66  {hi_wdata[65:34], lo_wdata[33:2], hi_we[1], lo_we[0]}.
REQ-008 data_sram_rdata  in  32  synchronous SRAM read data, valid in the cycle after address issue.
REQ-009 mem_to_wb_bus  out  70  {pc[69:38], rf_we[37], rf_waddr[36:32], rf_wdata[31:0]}.
REQ-010 hilo_mem_to_wb_bus  out  66  same layout as hilo_ex_to_mem_bus.
REQ-011 mem_wreg / mem_waddr / mem_wdata  out  1/5/32  forwarding copy of the WB bus GPR write fields.
REQ-012 mem_hi_we / mem_lo_we / mem_hi_wdata / mem_lo_wdata  out  1/1/32/32  HI/LO forwarding.
REQ-013 mem_adel  out  1  load address misaligned, combinational from the MEM register.

Function
REQ-014 The pipeline register SHALL follow this priority: rst -> all zero; else stall[3]=1 & stall[4]=0 -> all zero (bubble); else stall[3]=0 -> capture both input buses; else hold.
REQ-015 A load SHALL be defined as registered data_ram_en=1, data_ram_wen=0 and sel_rf_res=1.
REQ-016 load_op encoding SHALL be: 000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU; codes 101-111 SHALL be treated as LW.
REQ-017 Byte select SHALL be ex_result[1:0]: LB/LBU take byte at bits [8*a+7:8*a]; LH/LHU take bits [15:0] for a=00 and [31:16] for a=10.
REQ-018 Extension SHALL be: LB/LH sign-extend to 32; LBU/LHU zero-extend to 32; LW passes through.
REQ-019 mem_adel SHALL be 1 when a load is active and either (LH/LHU and ex_result[0]=1) or (LW and ex_result[1:0]!=0); otherwise 0.
REQ-020 When mem_adel=1, the output rf_we and mem_wreg SHALL be forced to 0.
REQ-021 rf_wdata SHALL be the extended load data when sel_rf_res=1; otherwise ex_result.
REQ-022 An rdata hold register SHALL exist with two states: EMPTY and HELD.
REQ-023 EMPTY -> HELD SHALL occur when a load is in MEM and stall[4]=1; on this transition the hold register SHALL latch data_sram_rdata.
REQ-024 HELD -> EMPTY SHALL occur when the MEM register captures new content (stall[3]=0) or on rst.
REQ-025 In HELD, load extraction SHALL use the held word and ignore data_sram_rdata.
REQ-026 All outputs SHALL be purely combinational from the MEM register and the hold register; there SHALL be no additional latency, giving a total latency from EX capture to the WB bus of 1 cycle.
REQ-027 hilo fields SHALL pass through unmodified; HI/LO forwarding outputs SHALL equal the registered HI/LO fields.
REQ-028 Under a bubble, every output SHALL be 0, including mem_adel.

Reset
REQ-029 After a rst cycle, the MEM register, the hold register and the hold state SHALL all be 0/EMPTY.
REQ-030 After a rst cycle, every output SHALL read 0.
REQ-031 A rst asserted mid-stall SHALL override the stall and the hold.

Verification
REQ-032 LB, addr ...0003, rdata 0x80FF_1234 -> rf_wdata 0xFFFF_FF80, rf_we=1.
REQ-033 LHU, addr ...0002, rdata 0x8001_7FFF -> rf_wdata 0x0000_8001; LH, addr ...0001 -> mem_adel=1, rf_we=0.
REQ-034 LW with stall[4]=1 for 3 cycles, rdata changed to 0xDEAD_BEEF after the first cycle, original rdata 0x1234_5678 -> rf_wdata stays 0x1234_5678 throughout.
REQ-035 stall = 6'b001000 for one cycle -> next cycle mem_to_wb_bus = 0 and mem_wreg = 0.
REQ-036 Non-load ALU op, ex_result 0x0000_00AA, rf_waddr 5 -> mem_wdata 0xAA, mem_waddr 5; hilo input 0x1 / 0x2 with hi_we = lo_we = 1 -> forwarding outputs match.
REQ-037 rst asserted while HELD -> next cycle all outputs are 0 and the hold state is EMPTY.
